// File: rtl/mult_ppg_csa_stage_if.sv
// Operand/result bundle for the partial-product + carry-save stage.
// Handshake rule (both sides): a transfer happens at a rising clk edge when
// valid and ready are both high; a producer holds valid and its payload
// stable until that edge, and ready may depend combinationally on the
// downstream ready.
interface mult_ppg_csa_stage_if #(
  parameter int WIDTH = 4,
  parameter int TAG_W = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic [TAG_W-1:0]     in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   row_s;
  logic [2*WIDTH-1:0]   row_c;
  logic [TAG_W-1:0]     out_tag;

  // Stage side: consumes operands, produces carry-save rows
  modport slave (
    input  in_valid, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, row_s, row_c, out_tag
  );

  // Environment side: supplies operands, consumes rows
  modport master (
    output in_valid, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, row_s, row_c, out_tag
  );
endinterface

// File: rtl/mult_ppg_csa_stage.sv
// Unsigned multiplier front end: AND partial-product generation (stage P)
// followed by carry-save reduction to two rows (stage R). Two-deep elastic
// pipeline; (row_s + row_c) mod 2^(2*WIDTH) equals in_a * in_b.
module mult_ppg_csa_stage #(
  parameter int WIDTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mult_ppg_csa_stage_if.slave   bus
);
  localparam int PW = 2 * WIDTH;

  // Stage valid flags
  logic vp_q, vp_d;
  logic vr_q, vr_d;

  // Stage P payload: shifted partial products and tag
  logic [PW-1:0]    pp_q [WIDTH];
  logic [PW-1:0]    pp_d [WIDTH];
  logic [TAG_W-1:0] tag_p_q, tag_p_d;

  // Stage R payload: the two carry-save rows and tag (these are the outputs)
  logic [PW-1:0]    row_s_q, row_s_d;
  logic [PW-1:0]    row_c_q, row_c_d;
  logic [TAG_W-1:0] tag_r_q, tag_r_d;

  // Flow-control terms
  logic adv_r;
  logic in_ready_c;
  logic accept;

  // Reduction results from the carry-save array
  logic [PW-1:0] red_s;
  logic [PW-1:0] red_c;
  logic [PW-1:0] csa_s;
  logic [PW-1:0] csa_c;

  // Per-stage advance: R takes P when R is empty or draining; P refills when it empties or moves on
  always_comb begin
    adv_r      = vp_q & (~vr_q | bus.out_ready);
    in_ready_c = ~vp_q | adv_r;
    accept     = bus.in_valid & in_ready_c;

    vp_d = vp_q;
    if (accept) begin
      vp_d = 1'b1;
    end else if (adv_r) begin
      vp_d = 1'b0;
    end

    vr_d = vr_q;
    if (adv_r) begin
      vr_d = 1'b1;
    end else if (bus.out_ready & vr_q) begin
      vr_d = 1'b0;
    end
  end

  // Partial-product generation: row j is in_a gated by in_b[j], placed at weight 2^j
  always_comb begin
    for (int j = 0; j < WIDTH; j++) begin
      pp_d[j] = pp_q[j];
      if (accept) begin
        pp_d[j] = {{WIDTH{1'b0}}, bus.in_a & {WIDTH{bus.in_b[j]}}} << j;
      end
    end
    tag_p_d = accept ? bus.in_tag : tag_p_q;
  end

  // Carry-save array: fold each partial product into the running (sum, carry) pair with a 3:2
  // compressor per bit; the first step has a zero carry row so it acts as a 2:2 half-adder layer.
  // The carry shift discards only weight 2^(2*WIDTH), which the mod-2^(2*WIDTH) result ignores.
  always_comb begin
    red_s = pp_q[0];
    red_c = '0;
    csa_s = '0;
    csa_c = '0;
    for (int j = 1; j < WIDTH; j++) begin
      csa_s = red_s ^ red_c ^ pp_q[j];
      csa_c = ((red_s & red_c) | (red_s & pp_q[j]) | (red_c & pp_q[j])) << 1;
      red_s = csa_s;
      red_c = csa_c;
    end
  end

  // Stage R load: capture the reduced rows when P advances, otherwise hold (covers back-pressure)
  always_comb begin
    row_s_d = row_s_q;
    row_c_d = row_c_q;
    tag_r_d = tag_r_q;
    if (adv_r) begin
      row_s_d = red_s;
      row_c_d = red_c;
      tag_r_d = tag_p_q;
    end
  end

  // Valid flags and output registers; reset discards anything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vp_q    <= 1'b0;
      vr_q    <= 1'b0;
      row_s_q <= '0;
      row_c_q <= '0;
      tag_r_q <= '0;
    end else begin
      vp_q    <= vp_d;
      vr_q    <= vr_d;
      row_s_q <= row_s_d;
      row_c_q <= row_c_d;
      tag_r_q <= tag_r_d;
    end
  end

  // Stage P payload needs no reset: it is only consumed while vp_q is set
  always_ff @(posedge clk) begin
    pp_q    <= pp_d;
    tag_p_q <= tag_p_d;
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = vr_q;
  assign bus.row_s     = row_s_q;
  assign bus.row_c     = row_c_q;
  assign bus.out_tag   = tag_r_q;
endmodule
